// File: rtl/mux_pack_param.sv
// Packs RATIO narrow input lanes into one wide output word, with optional early
// flush of a partially filled word. Lane order within the word is set by MSB_FIRST.
module mux_pack_param #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk_4f,
  input  logic                         reset,
  input  logic [IN_W-1:0]              data_in,
  input  logic                         valid_in,
  input  logic                         flush,
  output logic [IN_W*RATIO-1:0]        data_out,
  output logic                         valid_out,
  output logic [$clog2(RATIO+1)-1:0]   lanes_out,
  output logic                         idle
);

  localparam int W     = IN_W * RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LW    = $clog2(RATIO + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     data_out_r;
  logic             valid_out_r;
  logic [LW-1:0]    lanes_out_r;

  logic [W-1:0]     acc_next_s;
  logic [LW-1:0]    fill_s;
  logic             last_lane_s;
  logic             emit_s;

  // Writes data into lane slot 'lane'; slot position depends on MSB_FIRST.
  function automatic logic [W-1:0] place_lane(
    input logic [W-1:0]     acc,
    input logic [CNT_W-1:0] lane,
    input logic [IN_W-1:0]  data
  );
    logic [W-1:0] res;
    int           slot;
    res = acc;
    for (int k = 0; k < RATIO; k++) begin
      slot = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
      if (lane == CNT_W'(k)) begin
        res[slot*IN_W +: IN_W] = data;
      end else begin
        res[slot*IN_W +: IN_W] = acc[slot*IN_W +: IN_W];
      end
    end
    return res;
  endfunction

  // Next accumulator contents and emit decision for this cycle.
  always_comb begin
    acc_next_s  = acc_r;
    fill_s      = LW'(cnt_r) + LW'(valid_in);
    last_lane_s = 1'b0;
    emit_s      = 1'b0;
    if (valid_in) begin
      acc_next_s  = place_lane(acc_r, cnt_r, data_in);
      last_lane_s = (cnt_r == CNT_W'(RATIO - 1));
    end else begin
      acc_next_s  = acc_r;
      last_lane_s = 1'b0;
    end
    // A flush with nothing pending and no incoming lane is a no-op.
    emit_s = last_lane_s || (flush && (fill_s != LW'(0)));
  end

  // Lane counter, accumulator and registered output word.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt_r       <= CNT_W'(0);
      acc_r       <= W'(0);
      data_out_r  <= W'(0);
      valid_out_r <= 1'b0;
      lanes_out_r <= LW'(0);
    end else begin
      valid_out_r <= emit_s;
      if (emit_s) begin
        data_out_r  <= acc_next_s;
        lanes_out_r <= fill_s;
        cnt_r       <= CNT_W'(0);
        acc_r       <= W'(0);
      end else if (valid_in) begin
        acc_r <= acc_next_s;
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
      end
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign lanes_out = lanes_out_r;
  assign idle      = (cnt_r == CNT_W'(0));

endmodule

// File: tb/tb_mux_pack_param.sv
// Directed bench for mux_pack_param: an MSB-first and an LSB-first instance
// share one stimulus stream; expected words are hand-computed.
module tb_mux_pack_param;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        flush;

  logic [31:0] data_out;
  logic        valid_out;
  logic [2:0]  lanes_out;
  logic        idle;

  logic [31:0] data_out_l;
  logic        valid_out_l;
  logic [2:0]  lanes_out_l;
  logic        idle_l;

  int n_pass  = 0;
  int n_total = 0;

  mux_pack_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .flush     (flush),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lanes_out (lanes_out),
    .idle      (idle)
  );

  mux_pack_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_dut_lsb (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .flush     (flush),
    .data_out  (data_out_l),
    .valid_out (valid_out_l),
    .lanes_out (lanes_out_l),
    .idle      (idle_l)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one input vector, let one rising edge pass, settle just after it.
  task automatic step(input logic [7:0] d, input logic v, input logic f);
    data_in  = d;
    valid_in = v;
    flush    = f;
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    logic [7:0] bytes_a [4];
    bytes_a[0] = 8'h2F; bytes_a[1] = 8'h5E; bytes_a[2] = 8'h8D; bytes_a[3] = 8'hBC;
    data_in = 8'h00; valid_in = 1'b0; flush = 1'b0; reset = 1'b1;
    @(posedge clk_4f); #1;
    step(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_data", data_out, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_lanes", {29'd0, lanes_out}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);

    // Consecutive full word
    for (int i = 0; i < 4; i++) begin
      step(bytes_a[i], 1'b1, 1'b0);
      if (i < 3) begin
        chk("b2b_novalid", {31'd0, valid_out}, 32'd0);
        chk("b2b_busy", {31'd0, idle}, 32'd0);
      end
    end
    chk("b2b_valid", {31'd0, valid_out}, 32'd1);
    chk("b2b_data", data_out, 32'h2F5E8DBC);
    chk("b2b_lanes", {29'd0, lanes_out}, 32'd4);
    chk("b2b_idle", {31'd0, idle}, 32'd1);
    chk("b2b_lsb_data", data_out_l, 32'hBC8D5E2F);
    step(8'h00, 1'b0, 1'b0);
    chk("b2b_pulse_end", {31'd0, valid_out}, 32'd0);
    chk("b2b_hold", data_out, 32'h2F5E8DBC);

    // Same bytes with two idle cycles after each
    for (int i = 0; i < 4; i++) begin
      step(bytes_a[i], 1'b1, 1'b0);
      if (i == 3) begin
        chk("gap_valid", {31'd0, valid_out}, 32'd1);
        chk("gap_data", data_out, 32'h2F5E8DBC);
      end else begin
        chk("gap_novalid", {31'd0, valid_out}, 32'd0);
      end
      for (int g = 0; g < 2; g++) begin
        step(8'h00, 1'b0, 1'b0);
        chk("gap_quiet", {31'd0, valid_out}, 32'd0);
      end
    end

    // Eight back-to-back bytes -> two words, pulses four cycles apart
    for (int i = 1; i <= 8; i++) begin
      step(8'(i), 1'b1, 1'b0);
      if (i == 4) begin
        chk("two_w0_valid", {31'd0, valid_out}, 32'd1);
        chk("two_w0_data", data_out, 32'h01020304);
      end else if (i == 8) begin
        chk("two_w1_valid", {31'd0, valid_out}, 32'd1);
        chk("two_w1_data", data_out, 32'h05060708);
      end else begin
        chk("two_novalid", {31'd0, valid_out}, 32'd0);
      end
    end
    step(8'h00, 1'b0, 1'b0);

    // Flush with no incoming lane
    step(8'h11, 1'b1, 1'b0);
    step(8'h22, 1'b1, 1'b0);
    chk("fl_pending", {31'd0, valid_out}, 32'd0);
    step(8'h00, 1'b0, 1'b1);
    chk("fl_valid", {31'd0, valid_out}, 32'd1);
    chk("fl_data", data_out, 32'h11220000);
    chk("fl_lanes", {29'd0, lanes_out}, 32'd2);
    chk("fl_idle", {31'd0, idle}, 32'd1);
    chk("fl_lsb_data", data_out_l, 32'h00002211);
    step(8'h00, 1'b0, 1'b0);
    chk("fl_pulse_end", {31'd0, valid_out}, 32'd0);

    // Flush together with a lane
    step(8'h11, 1'b1, 1'b0);
    step(8'h22, 1'b1, 1'b0);
    step(8'h33, 1'b1, 1'b1);
    chk("flv_valid", {31'd0, valid_out}, 32'd1);
    chk("flv_data", data_out, 32'h11223300);
    chk("flv_lanes", {29'd0, lanes_out}, 32'd3);
    step(8'h00, 1'b0, 1'b0);

    // Flush with nothing pending is ignored
    step(8'h00, 1'b0, 1'b1);
    chk("fl0_novalid", {31'd0, valid_out}, 32'd0);
    chk("fl0_hold", data_out, 32'h11223300);
    chk("fl0_lanes_hold", {29'd0, lanes_out}, 32'd3);

    // Flush coinciding with the last lane behaves as a normal full word
    step(8'hC1, 1'b1, 1'b0);
    step(8'hC2, 1'b1, 1'b0);
    step(8'hC3, 1'b1, 1'b0);
    step(8'hC4, 1'b1, 1'b1);
    chk("flf_valid", {31'd0, valid_out}, 32'd1);
    chk("flf_data", data_out, 32'hC1C2C3C4);
    chk("flf_lanes", {29'd0, lanes_out}, 32'd4);
    step(8'h00, 1'b0, 1'b0);
    chk("flf_idle", {31'd0, idle}, 32'd1);

    // Reset mid-word discards pending lanes and beats valid_in/flush
    step(8'h55, 1'b1, 1'b0);
    step(8'h66, 1'b1, 1'b0);
    step(8'h77, 1'b1, 1'b0);
    reset = 1'b1;
    step(8'h99, 1'b1, 1'b1);
    reset = 1'b0;
    chk("mrst_valid", {31'd0, valid_out}, 32'd0);
    chk("mrst_data", data_out, 32'h0);
    chk("mrst_lanes", {29'd0, lanes_out}, 32'd0);
    chk("mrst_idle", {31'd0, idle}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(8'hA0 + 8'(i), 1'b1, 1'b0);
      if (i < 4) chk("mrst_novalid", {31'd0, valid_out}, 32'd0);
    end
    chk("mrst_w_valid", {31'd0, valid_out}, 32'd1);
    chk("mrst_w_data", data_out, 32'hA1A2A3A4);

    // LSB-first ordering
    for (int i = 1; i <= 4; i++) step(8'(i), 1'b1, 1'b0);
    chk("lsb_valid", {31'd0, valid_out_l}, 32'd1);
    chk("lsb_data", data_out_l, 32'h04030201);
    chk("lsb_lanes", {29'd0, lanes_out_l}, 32'd4);
    chk("msb_data", data_out, 32'h01020304);
    step(8'h00, 1'b0, 1'b0);
    chk("lsb_pulse_end", {31'd0, valid_out_l}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_pack_param.md
MUX_PACK_PARAM -- requirements
Module: mux_pack_param

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, giving the input lane width in bits.
REQ-002 The block SHALL have parameter RATIO, default 4, giving the number of input lanes per output word; legal range 2..16, not required to be a power of two.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 = first accepted lane lands in the top bits, 0 = first accepted lane lands in the bottom bits.
REQ-004 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port data_in, input, IN_W bits: input lane data.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in is accepted on every clk_4f edge where valid_in=1.
REQ-008 The block SHALL have port flush, input, 1 bit: request to emit a partially filled word.
REQ-009 The block SHALL have port data_out, output, IN_W*RATIO bits: the packed word.
REQ-010 The block SHALL have port valid_out, output, 1 bit: one-cycle strobe marking a new data_out.
REQ-011 The block SHALL have port lanes_out, output, clog2(RATIO+1) bits: number of filled lanes in the current data_out.
REQ-012 The block SHALL have port idle, output, 1 bit: 1 when no lanes are pending.

Function
REQ-013 The block SHALL keep an internal lane counter cnt, range 0..RATIO-1, and an accumulator IN_W*RATIO bits wide.
REQ-014 On valid_in=1 the block SHALL write data_in into lane cnt and increment cnt; on valid_in=0, cnt and the accumulator SHALL hold, so gaps of any length are allowed.
REQ-015 Lane k (0 = first accepted) SHALL occupy bits [W-1-k*IN_W -: IN_W] when MSB_FIRST=1, and bits [k*IN_W +: IN_W] when MSB_FIRST=0, where W=IN_W*RATIO.
REQ-016 When a lane is accepted with cnt=RATIO-1, on the next edge the block SHALL drive data_out with the full word, set valid_out=1 and lanes_out=RATIO, reset cnt to 0 and clear the accumulator; latency is one cycle after the last lane.
REQ-017 Back-to-back input SHALL be supported with no bubble: the lane accepted in the cycle after a completing lane becomes lane 0 of the next word.
REQ-018 On flush=1 with valid_in=0 and cnt>0, the block SHALL emit the partial word on the next edge: unfilled lanes zero, lanes_out=cnt, valid_out=1, cnt to 0.
REQ-019 On flush=1 and valid_in=1 in the same cycle, the lane SHALL be accepted first, then the word SHALL be emitted with lanes_out=cnt+1; if that fills the word, behaviour SHALL be identical to REQ-016.
REQ-020 On flush=1 with cnt=0 and valid_in=0, the block SHALL do nothing: no valid_out, and data_out is unchanged.
REQ-021 valid_out SHALL be high for exactly one cycle per emitted word; data_out and lanes_out SHALL hold their last value while valid_out=0.
REQ-022 idle SHALL be combinational and equal to (cnt==0).

Reset
REQ-023 When reset=1 at an edge, the block SHALL set data_out=0, valid_out=0, lanes_out=0, cnt=0 and accumulator=0, so idle=1.
REQ-024 reset SHALL take priority over valid_in and flush; lanes pending at reset SHALL be discarded with no valid_out.

Verification (defaults unless stated)
REQ-025 Bench: after reset, drive bytes 0x2F,0x5E,0x8D,0xBC on consecutive cycles -> data_out=0x2F5E8DBC, valid_out=1 for one cycle the edge after 0xBC, lanes_out=4.
REQ-026 Bench: drive the same bytes with 2-cycle valid_in gaps -> same word; valid_out=1 only once, one cycle after the 4th byte.
REQ-027 Bench: drive 8 consecutive bytes 0x01..0x08 -> 0x01020304 then 0x05060708, with valid_out pulses 4 cycles apart.
REQ-028 Bench: drive 0x11,0x22, then flush with valid_in=0 -> data_out=0x11220000, lanes_out=2; then drive 0x11,0x22, then flush together with 0x33 -> data_out=0x11223300, lanes_out=3.
REQ-029 Bench: drive 3 bytes, assert reset for one cycle, then drive 0xA1..0xA4 -> no valid_out until data_out=0xA1A2A3A4.
REQ-030 Bench: with MSB_FIRST=0, drive 0x01,0x02,0x03,0x04 -> data_out=0x04030201.
